// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and parameter defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int RESET_PC_DEF   = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH_H = 2'b01,
        FETCH_L = 2'b10,
        ISSUE   = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Fetch address register with increment, branch load and modulo-2^ADDR_WIDTH wrap.
// One-cycle update; load takes priority over increment, no backpressure of its own.
module program_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_VAL = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    // Natural overflow of the add gives the wrap from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads (high then low) and issues them to execute.
// Zero-wait: 2 cycles IDLE->valid, 1 instr per 3 cycles; MemReq held until MemAck, InstrValid held until ExecReady.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RESET_PC   = RESET_PC_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Run,
    output logic                  MemReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemAck,
    input  logic [7:0]            MemData,
    output logic                  IRWrite,
    output logic                  IRLH,
    output logic [7:0]            IRData,
    output logic                  InstrValid,
    input  logic                  ExecReady,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCLoadValue,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [15:0]           InstrCount
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         pc_inc;
    logic         pc_load;
    logic         handshake;

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk        (Clock),
        .rst_n      (Reset),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (PCLoadValue),
        .pc         (PC)
    );

    assign MemAddr = PC;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // All outputs decode from state_q, so reset forcing IDLE clears them immediately.
    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        IRWrite    = 1'b0;
        IRLH       = 1'b0;
        IRData     = 8'h00;
        InstrValid = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        handshake  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = FETCH_H;
                end
            end
            FETCH_H: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    IRWrite = 1'b1;
                    IRLH    = 1'b1;
                    IRData  = MemData;
                    pc_inc  = 1'b1;
                    state_d = FETCH_L;
                end
            end
            FETCH_L: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    IRWrite = 1'b1;
                    IRData  = MemData;
                    pc_inc  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                InstrValid = 1'b1;
                if (ExecReady) begin
                    // Redirects only take effect on an instruction boundary.
                    handshake = 1'b1;
                    pc_load   = PCLoad;
                    state_d   = Run ? FETCH_H : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            InstrCount <= 16'h0000;
        end else if (handshake) begin
            InstrCount <= InstrCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: inputs driven 2 units after posedge, outputs checked 1 unit later.
module tb_instruction_fetch_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Run;
    logic       MemReq;
    logic [7:0] MemAddr;
    logic       MemAck;
    logic [7:0] MemData;
    logic       IRWrite;
    logic       IRLH;
    logic [7:0] IRData;
    logic       InstrValid;
    logic       ExecReady;
    logic       PCLoad;
    logic [7:0] PCLoadValue;
    logic [7:0] PC;
    logic [15:0] InstrCount;

    int n_cmp  = 0;
    int n_fail = 0;
    int irw_cnt = 0;
    int irw_base;

    instruction_fetch_unit #(
        .ADDR_WIDTH (8),
        .RESET_PC   (0)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Run         (Run),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemData     (MemData),
        .IRWrite     (IRWrite),
        .IRLH        (IRLH),
        .IRData      (IRData),
        .InstrValid  (InstrValid),
        .ExecReady   (ExecReady),
        .PCLoad      (PCLoad),
        .PCLoadValue (PCLoadValue),
        .PC          (PC),
        .InstrCount  (InstrCount)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (IRWrite === 1'b1) irw_cnt++;
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; MemAck = 1'b0; MemData = 8'h00;
        ExecReady = 1'b0; PCLoad = 1'b0; PCLoadValue = 8'h00;
        #3;
        chk("rst_memreq", 16'(MemReq), 16'd0);
        chk("rst_irwrite", 16'(IRWrite), 16'd0);
        chk("rst_irlh", 16'(IRLH), 16'd0);
        chk("rst_irdata", 16'(IRData), 16'h00);
        chk("rst_valid", 16'(InstrValid), 16'd0);
        chk("rst_pc", 16'(PC), 16'h00);
        chk("rst_count", InstrCount, 16'h0000);
        tick(); tick();
        Reset = 1'b1;

        // Zero-wait fetch of A5,3C
        tick();
        Run = 1'b1; MemAck = 1'b1; ExecReady = 1'b1; MemData = 8'hA5;
        #1;
        chk("idle_memreq", 16'(MemReq), 16'd0);
        chk("idle_ack_ignored", 16'(IRWrite), 16'd0);
        tick(); #1;
        chk("zw_h_memreq", 16'(MemReq), 16'd1);
        chk("zw_h_addr", 16'(MemAddr), 16'h00);
        chk("zw_h_irwrite", 16'(IRWrite), 16'd1);
        chk("zw_h_irlh", 16'(IRLH), 16'd1);
        chk("zw_h_irdata", 16'(IRData), 16'hA5);
        tick(); MemData = 8'h3C; #1;
        chk("zw_l_irwrite", 16'(IRWrite), 16'd1);
        chk("zw_l_irlh", 16'(IRLH), 16'd0);
        chk("zw_l_irdata", 16'(IRData), 16'h3C);
        chk("zw_l_addr", 16'(MemAddr), 16'h01);
        tick(); Run = 1'b0; MemAck = 1'b0; #1;
        chk("zw_valid_3rd", 16'(InstrValid), 16'd1);
        chk("zw_issue_memreq", 16'(MemReq), 16'd0);
        chk("zw_issue_irwrite", 16'(IRWrite), 16'd0);
        chk("zw_pc", 16'(PC), 16'h02);
        chk("zw_count_pre", InstrCount, 16'd0);
        tick(); #1;
        chk("zw_count", InstrCount, 16'd1);
        chk("zw_idle_valid", 16'(InstrValid), 16'd0);

        // MemAck delayed 3 cycles per byte
        Run = 1'b1; irw_base = irw_cnt;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dly_h_memreq", 16'(MemReq), 16'd1);
            chk("dly_h_addr", 16'(MemAddr), 16'h02);
            tick();
        end
        MemAck = 1'b1; MemData = 8'h11; #1;
        chk("dly_h_irlh", 16'(IRLH), 16'd1);
        tick(); MemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dly_l_memreq", 16'(MemReq), 16'd1);
            chk("dly_l_addr", 16'(MemAddr), 16'h03);
            tick();
        end
        MemAck = 1'b1; MemData = 8'h22; #1;
        chk("dly_l_irdata", 16'(IRData), 16'h22);
        tick(); MemAck = 1'b0; ExecReady = 1'b0;
        PCLoad = 1'b1; PCLoadValue = 8'h77;
        #1;
        chk("dly_irw_pulses", 16'(irw_cnt - irw_base), 16'd2);

        // ExecReady held low for 5 cycles in ISSUE; PCLoad there is ignored
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 16'(InstrValid), 16'd1);
            chk("stall_memreq", 16'(MemReq), 16'd0);
            chk("stall_count", InstrCount, 16'd1);
            tick();
        end
        chk("stall_pc", 16'(PC), 16'h04);

        // Handshake redirect to 40
        ExecReady = 1'b1; PCLoadValue = 8'h40; #1;
        tick(); PCLoad = 1'b0; MemAck = 1'b1; #1;
        chk("br_count", InstrCount, 16'd2);
        chk("br_addr", 16'(MemAddr), 16'h40);
        tick(); PCLoad = 1'b1; PCLoadValue = 8'h80; #1;
        chk("br_l_addr", 16'(MemAddr), 16'h41);
        tick(); PCLoad = 1'b0; #1;
        chk("br_fetchl_load_ignored", 16'(PC), 16'h42);
        tick(); #1;
        chk("br_seq_addr", 16'(MemAddr), 16'h42);
        chk("br_seq_count", InstrCount, 16'd3);

        // Redirect to FE and wrap through FF to 00
        tick(); tick();
        PCLoad = 1'b1; PCLoadValue = 8'hFE; #1;
        chk("wr_issue_pc", 16'(PC), 16'h44);
        tick(); PCLoad = 1'b0; #1;
        chk("wr_addr_fe", 16'(MemAddr), 16'hFE);
        tick(); #1;
        chk("wr_addr_ff", 16'(MemAddr), 16'hFF);
        tick(); #1;
        chk("wr_pc_00", 16'(PC), 16'h00);
        tick(); #1;
        chk("wr_addr_00", 16'(MemAddr), 16'h00);
        chk("wr_count", InstrCount, 16'd5);

        // Reset between the high and low acks
        MemData = 8'h99;
        tick(); #1;
        chk("mr_fetchl_irlh", 16'(IRLH), 16'd0);
        Reset = 1'b0; irw_base = irw_cnt; #1;
        chk("mr_memreq", 16'(MemReq), 16'd0);
        chk("mr_irwrite", 16'(IRWrite), 16'd0);
        chk("mr_irdata", 16'(IRData), 16'h00);
        chk("mr_pc", 16'(PC), 16'h00);
        chk("mr_count", InstrCount, 16'd0);
        chk("mr_valid", 16'(InstrValid), 16'd0);
        tick(); #1;
        Reset = 1'b1; MemAck = 1'b0; MemData = 8'h5A; #1;
        chk("mr_no_irw", 16'(irw_cnt - irw_base), 16'd0);
        tick(); MemAck = 1'b1; #1;
        chk("mr_next_irwrite", 16'(IRWrite), 16'd1);
        chk("mr_next_irlh", 16'(IRLH), 16'd1);
        chk("mr_next_irdata", 16'(IRData), 16'h5A);
        chk("mr_next_addr", 16'(MemAddr), 16'h00);
        tick(); MemAck = 1'b0; Run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ADDR_WIDTH, 8, program-counter and memory-address width.
- RESET_PC, 0, PC value loaded on reset.
REQ-002 Ports, one per line: name, direction, width, meaning:
- Clock, in, 1, single clock; all state updates on posedge.
- Reset, in, 1, asynchronous active-low reset.
- Run, in, 1, level; 1 = keep fetching, 0 = stop at the next instruction boundary.
- MemReq, out, 1, byte read request.
- MemAddr, out, ADDR_WIDTH, byte address of the request.
- MemAck, in, 1, read data valid this cycle.
- MemData, in, 8, read byte.
- IRWrite, out, 1, drives the instruction register Write input.
- IRLH, out, 1, drives the instruction register LH input; 1 = high byte, 0 = low byte.
- IRData, out, 8, drives the instruction register I input.
- InstrValid, out, 1, IR holds a complete instruction.
- ExecReady, in, 1, execute stage accepts the instruction.
- PCLoad, in, 1, branch redirect request.
- PCLoadValue, in, ADDR_WIDTH, redirect target.
- PC, out, ADDR_WIDTH, current fetch address.
- InstrCount, out, 16, count of issued instructions.
REQ-003 The block SHALL have one clock, Clock; reset SHALL be asynchronous and active-low on port Reset.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH_H, FETCH_L and ISSUE.
REQ-005 In IDLE, if Run=1, the FSM SHALL go to FETCH_H on the next edge; otherwise it SHALL stay in IDLE.
REQ-006 In FETCH_H and FETCH_L, MemReq SHALL be 1 and MemAddr SHALL equal PC; in IDLE and ISSUE, MemReq SHALL be 0.
REQ-007 MemReq SHALL stay asserted until MemAck; MemAck in the same cycle MemReq first rises SHALL be honoured (zero-wait).
REQ-008 In FETCH_H with MemAck=1, combinationally: IRWrite=1, IRLH=1, IRData=MemData. On that edge PC SHALL become PC+1 and the FSM SHALL go to FETCH_L.
REQ-009 In FETCH_L with MemAck=1, combinationally: IRWrite=1, IRLH=0, IRData=MemData. On that edge PC SHALL become PC+1 and the FSM SHALL go to ISSUE.
REQ-010 IRWrite SHALL be 0 in all other cycles; MemAck outside FETCH_H/FETCH_L SHALL be ignored.
REQ-011 InstrValid SHALL be 1 exactly while in ISSUE.
REQ-012 A handshake SHALL occur when InstrValid=1 and ExecReady=1. On the handshake:
- InstrCount SHALL increment by 1, wrapping at 16'hFFFF to 0.
- The FSM SHALL go to FETCH_H if Run=1, else to IDLE.
REQ-013 PCLoad SHALL be sampled only in a handshake cycle; there PC SHALL become PCLoadValue. PCLoad in any other cycle SHALL be ignored.
REQ-014 PC arithmetic SHALL be modulo 2^ADDR_WIDTH; an increment from all-ones SHALL wrap to 0.
REQ-015 Run=0 during FETCH_H, FETCH_L or ISSUE SHALL NOT abort the instruction in progress; the FSM SHALL return to IDLE only after the handshake.
REQ-016 Fetch latency SHALL be 2 cycles from leaving IDLE to InstrValid=1 when memory is zero-wait.
REQ-017 Fetch throughput SHALL be one instruction per 3 cycles when memory is zero-wait and ExecReady=1.

Reset
REQ-018 While Reset=0, independent of Clock, the block SHALL force:
- State to IDLE and PC to RESET_PC.
- InstrCount to 0.
- MemReq, IRWrite, IRLH and InstrValid to 0.
- IRData to 8'h00.
REQ-019 Reset asserted mid-fetch SHALL abandon the partial instruction; no IRWrite SHALL occur after release until a new MemAck in FETCH_H.

Structure
REQ-020 A shared package fetch_pkg SHALL hold the FSM state encoding (2-bit) and the ADDR_WIDTH and RESET_PC defaults.
REQ-021 The PC register, with increment, load and wrap, SHALL be a sub-module named program_counter; the FSM and counter SHALL stay in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Zero-wait memory, MemData 8'hA5 then 8'h3C, Run=1, ExecReady=1 -> IRWrite pulses with IRLH=1/IRData=A5 then IRLH=0/IRData=3C; InstrValid=1 in the third cycle; PC=2; InstrCount=1.
- MemAck delayed 3 cycles per byte -> MemReq and MemAddr held steady throughout; exactly two IRWrite pulses per instruction.
- ExecReady=0 for 5 cycles in ISSUE -> InstrValid held, no MemReq, InstrCount unchanged until ExecReady=1.
- Handshake with PCLoad=1, PCLoadValue=8'h40 -> next MemAddr=8'h40; PCLoad=1 during FETCH_L -> ignored, PC continues sequentially.
- Start from PC=8'hFE -> fetch addresses FE, FF, then 00 on the next instruction.
- Reset=0 asserted between the FETCH_H and FETCH_L acks -> outputs cleared immediately, PC=RESET_PC, next IRWrite has IRLH=1.
